// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 timing constants, lock FSM states and error codes.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY    = 800;
    localparam int VGA_H_SYNC_PULSE = 128;
    localparam int VGA_H_BP         = 88;
    localparam int VGA_H_TOTAL      = 1056;
    localparam int VGA_V_DISPLAY    = 600;
    localparam int VGA_V_SYNC_PULSE = 4;
    localparam int VGA_V_BP         = 23;
    localparam int VGA_V_TOTAL      = 628;
    localparam int VGA_LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    localparam logic [1:0] ERR_LINE_PERIOD = 2'd0;
    localparam logic [1:0] ERR_HSYNC_WIDTH = 2'd1;
    localparam logic [1:0] ERR_FRAME_LINES = 2'd2;
    localparam logic [1:0] ERR_VSYNC_WIDTH = 2'd3;

endpackage

// File: rtl/vga_pulse_meter.sv
// Edge detector plus period and low-width counter for one active-low sync.
// Both counters advance only on cycles with en set; the period counter is
// cleared by the first enabled cycle at or after a falling edge.
module vga_pulse_meter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig,
    input  logic         en,
    output logic         fall,
    output logic         rise,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_q,
    output logic         sat,
    output logic [W-1:0] width_q
);
    import vga_timing_pkg::*;

    logic sig_q;
    logic armed;

    assign fall = sig_q & ~sig;
    assign rise = ~sig_q & sig;
    assign sat  = &cnt_q;

    // Period count seen by the current cycle: restart on the clearing event, saturate otherwise
    always_comb begin
        cnt = cnt_q;
        if (en) begin
            if (fall || armed)
                cnt = '0;
            else if (!sat)
                cnt = cnt_q + 1'b1;
        end
    end

    // Edge history, period count and low-width count
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q   <= 1'b1;
            armed   <= 1'b0;
            cnt_q   <= '0;
            width_q <= '0;
        end else begin
            sig_q <= sig;
            cnt_q <= cnt;
            armed <= (fall | armed) & ~en;
            if (fall)
                width_q <= en ? W'(1) : '0;
            else if (!sig && en && !(&width_q))
                width_q <= width_q + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a received VGA stream, checks
// line/frame timing and runs the SEARCH/ACQUIRE/LOCKED lock machine.
module vga_sync_decoder #(
    parameter int H_DISPLAY    = vga_timing_pkg::VGA_H_DISPLAY,
    parameter int H_SYNC_PULSE = vga_timing_pkg::VGA_H_SYNC_PULSE,
    parameter int H_BP         = vga_timing_pkg::VGA_H_BP,
    parameter int H_TOTAL      = vga_timing_pkg::VGA_H_TOTAL,
    parameter int V_DISPLAY    = vga_timing_pkg::VGA_V_DISPLAY,
    parameter int V_SYNC_PULSE = vga_timing_pkg::VGA_V_SYNC_PULSE,
    parameter int V_BP         = vga_timing_pkg::VGA_V_BP,
    parameter int V_TOTAL      = vga_timing_pkg::VGA_V_TOTAL,
    parameter int LOCK_FRAMES  = vga_timing_pkg::VGA_LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_valid,
    output logic [3:0] pixel_r,
    output logic [3:0] pixel_g,
    output logic [3:0] pixel_b,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [1:0] err_code
);
    import vga_timing_pkg::*;

    localparam logic [10:0] H_OFF = 11'(H_SYNC_PULSE + H_BP);
    localparam logic [10:0] H_END = 11'(H_SYNC_PULSE + H_BP + H_DISPLAY);
    localparam logic [9:0]  V_OFF = 10'(V_SYNC_PULSE + V_BP - 1);
    localparam logic [9:0]  V_END = 10'(V_SYNC_PULSE + V_BP - 1 + V_DISPLAY);

    logic        hs1, vs1;
    logic [3:0]  r1, g1, b1;
    logic        h_fall, h_rise, h_sat;
    logic [10:0] h_cnt, h_cnt_q, h_width_q;
    logic        v_fall, v_rise, l_sat;
    logic [9:0]  l_cnt, l_cnt_q, v_width_q;
    logic [3:0]  err;
    logic        err_any, report;
    logic [1:0]  err_sel;
    lock_state_t state, state_nx;
    logic [3:0]  good_cnt, good_nx;
    logic [10:0] x_off;
    logic [9:0]  y_off;
    logic        pix_ok;

    // S1: register everything off the connector once
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1 <= 1'b1;
            vs1 <= 1'b1;
            r1  <= '0;
            g1  <= '0;
            b1  <= '0;
        end else begin
            hs1 <= hsync_in;
            vs1 <= vsync_in;
            r1  <= r_in;
            g1  <= g_in;
            b1  <= b_in;
        end
    end

    vga_pulse_meter #(.W(11)) u_hmeter (
        .clk(clk), .reset(reset), .sig(hs1), .en(1'b1),
        .fall(h_fall), .rise(h_rise), .cnt(h_cnt), .cnt_q(h_cnt_q),
        .sat(h_sat), .width_q(h_width_q)
    );

    // Lines are counted in hsync falling edges
    vga_pulse_meter #(.W(10)) u_vmeter (
        .clk(clk), .reset(reset), .sig(vs1), .en(h_fall),
        .fall(v_fall), .rise(v_rise), .cnt(l_cnt), .cnt_q(l_cnt_q),
        .sat(l_sat), .width_q(v_width_q)
    );

    assign err[0]  = (h_fall && h_cnt_q != 11'(H_TOTAL - 1)) || h_sat;
    assign err[1]  = h_rise && h_width_q != 11'(H_SYNC_PULSE);
    assign err[2]  = (v_fall && l_cnt_q != 10'(V_TOTAL - 1)) || l_sat;
    assign err[3]  = v_rise && v_width_q != 10'(V_SYNC_PULSE);
    assign err_any = |err;

    // Lowest-numbered violation wins when several coincide
    always_comb begin
        err_sel = ERR_VSYNC_WIDTH;
        if (err[0])      err_sel = ERR_LINE_PERIOD;
        else if (err[1]) err_sel = ERR_HSYNC_WIDTH;
        else if (err[2]) err_sel = ERR_FRAME_LINES;
    end

    // Lock FSM next state; violations only count once a frame has been aligned
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        report   = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                end
            end
            ACQUIRE: begin
                report = 1'b1;
                if (err_any)
                    state_nx = SEARCH;
                else if (v_fall) begin
                    good_nx = good_cnt + 4'd1;
                    if (good_nx == 4'(LOCK_FRAMES))
                        state_nx = LOCKED;
                end
            end
            LOCKED: begin
                report = 1'b1;
                if (err_any)
                    state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
        end
    end

    assign x_off  = h_cnt - H_OFF;
    assign y_off  = l_cnt - V_OFF;
    assign pix_ok = (h_cnt >= H_OFF) && (h_cnt < H_END) &&
                    (l_cnt >= V_OFF) && (l_cnt < V_END) && (state == LOCKED);

    // S2: output register, two clocks after the connector sample
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x     <= 10'h3FF;
            pixel_y     <= 10'h3FF;
            pixel_valid <= 1'b0;
            pixel_r     <= '0;
            pixel_g     <= '0;
            pixel_b     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            err_code    <= '0;
        end else begin
            pixel_valid <= pix_ok;
            pixel_x     <= pix_ok ? x_off[9:0] : 10'h3FF;
            pixel_y     <= pix_ok ? y_off : 10'h3FF;
            pixel_r     <= pix_ok ? r1 : 4'd0;
            pixel_g     <= pix_ok ? g1 : 4'd0;
            pixel_b     <= pix_ok ? b1 : 4'd0;
            frame_start <= pix_ok && x_off == '0 && y_off == '0;
            locked      <= (state == LOCKED);
            timing_err  <= report && err_any;
            if (report && err_any)
                err_code <= err_sel;
        end
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive end of the console's 800x600@60 VGA link, clocked by the same 40 MHz pixel clock as the video output.
- Takes hsync/vsync/RGB as driven onto the connector (registered timing-generator outputs) and recovers pixel coordinates and colours.
- Checks every line and frame against nominal timing and runs a lock state machine.
- Used for on-board loopback self-test and as the frame-capture front end feeding a checksum/compare block.

Parameters:
H_DISPLAY, 800, active pixels per line
H_SYNC_PULSE, 128, hsync low width in clocks
H_BP, 88, clocks from hsync rise to pixel 0
H_TOTAL, 1056, clocks per line
V_DISPLAY, 600, active lines per frame
V_SYNC_PULSE, 4, hsync falling edges seen while vsync low
V_BP, 23, lines between vsync end and line 0
V_TOTAL, 628, hsync falling edges per frame
LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15)

Ports:
clk  in  1  pixel clock, 40 MHz
reset  in  1  synchronous, active-high
hsync_in  in  1  received hsync, active low
vsync_in  in  1  received vsync, active low
r_in  in  4  received red
g_in  in  4  received green
b_in  in  4  received blue
pixel_x  out  10  recovered column 0..799; 10'h3FF when not valid
pixel_y  out  10  recovered row 0..599; 10'h3FF when not valid
pixel_valid  out  1  pixel_x/y/rgb hold an active pixel and locked=1
pixel_r  out  4  red of the recovered pixel
pixel_g  out  4  green of the recovered pixel
pixel_b  out  4  blue of the recovered pixel
frame_start  out  1  one-cycle pulse coincident with pixel (0,0) while locked
locked  out  1  lock FSM is in LOCKED
timing_err  out  1  one-cycle pulse on any timing violation
err_code  out  2  cause of last timing_err (0 line period, 1 hsync width, 2 frame lines, 3 vsync width); holds until the next error

Behaviour:
- Reset is synchronous and active-high. Every register clears on reset:
  - pixel_x/y = 10'h3FF; pixel_valid, frame_start, locked, timing_err = 0.
  - pixel_r/g/b = 0, err_code = 0, FSM = SEARCH, all counters = 0.
  - Input sample registers load 1 for syncs and 0 for colours.
- Input stage: all inputs are registered once (stage S1). Edge detection compares S1 against its previous value.
- Horizontal counter h_cnt (11 bits, saturates at 2047):
  - Cleared to 0 on the cycle an hsync falling edge is detected; increments otherwise.
  - At each falling edge, the previous h_cnt must equal H_TOTAL-1, else error code 0.
  - Saturation is also error code 0 (lost sync).
- hsync width: low-cycle count at the rising edge must equal H_SYNC_PULSE, else error code 1.
- Line counter l_cnt (10 bits):
  - Cleared at the first hsync falling edge after a vsync falling edge; increments on each later hsync falling edge.
  - At a vsync falling edge, the previous l_cnt must equal V_TOTAL-1, else error code 2.
  - Saturation at 1023 is also error code 2.
- vsync width: hsync falling edges counted while vsync is low, checked at the vsync rise; must equal V_SYNC_PULSE, else error code 3.
- Coordinate mapping:
  - x = h_cnt - (H_SYNC_PULSE+H_BP) = h_cnt - 216; valid for x in 0..H_DISPLAY-1.
  - y = l_cnt - (V_SYNC_PULSE+V_BP-1) = l_cnt - 26; valid for y in 0..V_DISPLAY-1.
- Output timing:
  - Outputs are registered from S1, so the output register is S2.
  - Latency is exactly 2 clocks from the input cycle carrying a pixel's colour to pixel_valid with that colour.
  - When not valid, pixel_x/y = 10'h3FF and rgb = 0.
- Lock FSM:
  - SEARCH: wait for a vsync falling edge, then clear good_cnt and go to ACQUIRE. No error is reported on the first partial frame.
  - ACQUIRE: any violation returns to SEARCH. Each error-free frame (closed by the next vsync falling edge with l_cnt correct) increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1 and pixel_valid is allowed. Any violation makes timing_err pulse, locked drop the next cycle, and the FSM return to SEARCH.
- timing_err pulses in ACQUIRE and LOCKED only. With simultaneous violations, err_code takes the lowest code.
- A vsync falling edge and an hsync falling edge in the same cycle: the vsync falling edge is processed first, then the hsync edge becomes l_cnt=0.
- Reset mid-frame returns the block to SEARCH with no error pulse.

Decomposition:
- Package vga_timing_pkg holds:
  - the 800x600 timing constants, shared with the timing generator;
  - the lock state enum (SEARCH, ACQUIRE, LOCKED);
  - the err_code constants.
- One sub-module, vga_pulse_meter, instantiated twice:
  - generic edge detector plus period/width counter with a count-enable input;
  - horizontal instance counts clocks, vertical instance counts hsync falling edges.

Test Plan:
- Nominal 800x600 stream from the timing generator (loopback) -> locked rises at the close of the 3rd vsync falling edge; no timing_err; frame_start every 663168 clocks.
- Locked stream with rgb = pixel_x[3:0] pattern -> at pixel_valid, pixel_x=5 and pixel_y=7 give pixel_r=5; output appears 2 clocks after input colour; exactly 800 valid per line and 600 lines per frame.
- Stretch one line to 1057 clocks while locked -> timing_err pulse with err_code=0, locked=0 the next cycle, relock after 2 clean frames.
- hsync low for 127 clocks in one line -> err_code=1. vsync low for 3 lines -> err_code=3. Frame of 627 lines -> err_code=2.
- Hold hsync_in high for 2100 clocks -> counter saturates, err_code=0, FSM in SEARCH, pixel_x/y=3FF.
- Assert reset for 1 cycle mid-frame while locked -> next cycle all outputs at reset values, no timing_err, relock after the normal lock sequence.
